alu_arbiter: RTL and testbench

- Shares one combinational 8-op ALU instance (oc/a/b -> f, DATA_WIDTH wide) between two requesters, using round-robin arbitration.
- Registers the winning request's opcode and operands, evaluates the ALU for one cycle, captures the result, and returns it on one shared response channel tagged with the requester id.
- Sits between two command sources (e.g. the CPU execute stage and a DMA/accelerator path) and the arithmetic datapath.

---
 rtl/alu_arbiter_if.sv | 37 +++
 rtl/alu_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Two-requester command bundle plus shared tagged response channel for alu_arbiter.
// master = command sources / response consumer side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [2:0]            req0_oc;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [2:0]            req1_oc;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_f;
  logic                  rsp_err;

  modport master (
    output req0_valid, req0_oc, req0_a, req0_b,
    output req1_valid, req1_oc, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_f, rsp_err
  );

  modport slave (
    input  req0_valid, req0_oc, req0_a, req0_b,
    input  req1_valid, req1_oc, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_f, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one 8-op ALU between two requesters; accept -> rsp_valid 2 cycles later.
// Response held until rsp_ready; no new grant until it drains. Optional: ALU_ARBITER_DIVZ_EN.
module alu_arbiter_alu #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [2:0]            oc,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] f
);
  always_comb begin
    f = '0;
    case (oc)
      3'b000:  f = a + b;
      3'b001:  f = a - b;
      3'b010:  f = a * b;
      3'b011:  f = a / b;
      3'b100:  f = ~a;
      3'b101:  f = a ^ b;
      3'b110:  f = a | b;
      default: f = a & b;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int HIGH       = DATA_WIDTH - 1
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [2:0]    oc;
    logic [HIGH:0] a;
    logic [HIGH:0] b;
  } cmd_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  cmd_t          cmd_q, cmd_d;
  logic          id_q, id_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [HIGH:0] rsp_f_q, rsp_f_d;
  logic          rsp_err_q, rsp_err_d;

  logic          grant0, grant1;
  logic          divz;
  logic [HIGH:0] alu_f;

  // On a tie the requester that did not win last time gets the grant.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);

  alu_arbiter_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .oc (cmd_q.oc),
    .a  (cmd_q.a),
    .b  (cmd_q.b),
    .f  (alu_f)
  );

`ifdef ALU_ARBITER_DIVZ_EN
  assign divz = (cmd_q.oc == 3'b011) && (cmd_q.b == '0);
`else
  assign divz = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cmd_q        <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_f_q      <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_q        <= cmd_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_f_q      <= rsp_f_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_d        = cmd_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_f_d      = rsp_f_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          state_d      = EXEC;
          id_d         = grant1;
          last_grant_d = grant1;
          cmd_d.oc     = grant1 ? bus.req1_oc : bus.req0_oc;
          cmd_d.a      = grant1 ? bus.req1_a  : bus.req0_a;
          cmd_d.b      = grant1 ? bus.req1_b  : bus.req0_b;
        end
      end
      EXEC: begin
        rsp_f_d     = divz ? '1 : alu_f;
        rsp_err_d   = divz;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = (state_q == IDLE) & grant0;
    bus.req1_ready = (state_q == IDLE) & grant1;
    bus.rsp_valid  = rsp_valid_q;
    bus.rsp_id     = id_q;
    bus.rsp_f      = rsp_f_q;
    bus.rsp_err    = rsp_err_q;
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model checked every cycle.
// Define ALU_ARBITER_DIVZ_EN to also exercise the divide-by-zero result.
module tb_alu_arbiter;
  localparam int DW = 16;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  alu_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  alu_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {err, f} from the opcode definitions using plain integer arithmetic.
  function automatic logic [16:0] model_alu(input logic [2:0] oc, input logic [15:0] a,
                                            input logic [15:0] b);
    int unsigned ua, ub, r;
    logic        e;
    ua = a;
    ub = b;
    e  = 1'b0;
    case (oc)
      3'd0: r = (ua + ub) % 65536;
      3'd1: r = (ua + 65536 - ub) % 65536;
      3'd2: r = (ua * ub) % 65536;
      3'd3: begin
        if (ub == 0) begin
          r = 65535;
          e = 1'b1;
        end else r = ua / ub;
      end
      3'd4: r = 65535 - ua;
      3'd5: r = ua ^ ub;
      3'd6: r = ua | ub;
      default: r = ua & ub;
    endcase
    return {e, r[15:0]};
  endfunction

  // Reference model: idle, or waiting on one accepted op whose response is due
  // two cycles after acceptance and leaves once the consumer takes it.
  bit          m_idle = 1'b1;
  int          m_wait = 0;
  bit          m_last = 1'b1;
  bit          e_id;
  logic [15:0] e_f;
  bit          e_err;
  bit          e_chkf;

  always @(negedge clk) begin
    bit          g0, g1, ev;
    logic [16:0] res;
    if (rst) begin
      m_idle = 1'b1;
      m_wait = 0;
      m_last = 1'b1;
    end else begin
      g0 = bus.req0_valid && (!bus.req1_valid || m_last == 1'b1);
      g1 = bus.req1_valid && (!bus.req0_valid || m_last == 1'b0);
      if (!m_idle && m_wait > 0) m_wait--;
      chk("mon_req0_ready", {31'd0, bus.req0_ready}, {31'd0, m_idle && g0});
      chk("mon_req1_ready", {31'd0, bus.req1_ready}, {31'd0, m_idle && g1});
      ev = !m_idle && (m_wait == 0);
      chk("mon_rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, ev});
      if (ev) begin
        chk("mon_rsp_id", {31'd0, bus.rsp_id}, {31'd0, e_id});
        if (e_chkf) chk("mon_rsp_f", {16'd0, bus.rsp_f}, {16'd0, e_f});
`ifdef ALU_ARBITER_DIVZ_EN
        chk("mon_rsp_err", {31'd0, bus.rsp_err}, {31'd0, e_err});
`endif
      end
`ifndef ALU_ARBITER_DIVZ_EN
      chk("mon_rsp_err_zero", {31'd0, bus.rsp_err}, 32'd0);
`endif
      if (m_idle) begin
        if (g0 || g1) begin
          e_id = g1;
          res  = g1 ? model_alu(bus.req1_oc, bus.req1_a, bus.req1_b)
                    : model_alu(bus.req0_oc, bus.req0_a, bus.req0_b);
          e_f  = res[15:0];
          e_err = res[16];
`ifdef ALU_ARBITER_DIVZ_EN
          e_chkf = 1'b1;
`else
          e_chkf = !res[16];
`endif
          m_last = g1;
          m_idle = 1'b0;
          m_wait = 2;
        end
      end else if (ev && bus.rsp_ready) begin
        m_idle = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input logic [2:0] oc, input logic [15:0] a,
                         input logic [15:0] b);
    if (id) begin
      bus.req1_oc = oc; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_oc = oc; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end
  endtask

  task automatic issue(input bit id, input logic [2:0] oc, input logic [15:0] a,
                       input logic [15:0] b);
    bit ok;
    ok = 1'b0;
    set_req(id, oc, a, b);
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: ready never seen for requester %0d", id);
    end
  endtask

  task automatic wait_rsp(input string name, input bit id, input logic [15:0] f,
                          input bit err, input bit chk_err);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) found = 1'b1;
    end
    if (!found) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: no response within bound", name);
    end else begin
      chk({name, "_id"}, {31'd0, bus.rsp_id}, {31'd0, id});
      chk({name, "_f"}, {16'd0, bus.rsp_f}, {16'd0, f});
      if (chk_err) chk({name, "_err"}, {31'd0, bus.rsp_err}, {31'd0, err});
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_oc = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_oc = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    chk("reset_rsp_f", {16'd0, bus.rsp_f}, 32'd0);
    chk("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("reset_readys", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    tick();

    // Single add: ready in cycle 0, response in cycle 2, gone in cycle 3.
    bus.rsp_ready = 1'b1;
    set_req(1'b0, 3'b000, 16'h0003, 16'h0004);
    #1;
    chk("add_ready_c0", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    chk("add_valid_c1", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    chk("add_valid_c2", {31'd0, bus.rsp_valid}, 32'd1);
    chk("add_id_c2", {31'd0, bus.rsp_id}, 32'd0);
    chk("add_f_c2", {16'd0, bus.rsp_f}, 32'h0007);
    tick();
    chk("add_valid_c3", {31'd0, bus.rsp_valid}, 32'd0);

    // Fairness after a fresh reset: both continuously valid.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(1'b0, 3'b001, 16'd10, 16'd3);
    set_req(1'b1, 3'b010, 16'h0100, 16'h0100);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) wait_rsp("rr_req0", 1'b0, 16'h0007, 1'b0, 1'b0);
      else            wait_rsp("rr_req1", 1'b1, 16'h0000, 1'b0, 1'b0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();

    // Stalled response: held stable, no grants while it waits.
    bus.rsp_ready = 1'b0;
    set_req(1'b1, 3'b011, 16'd100, 16'd7);
    #1;
    chk("stall_req1_ready", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    set_req(1'b0, 3'b000, 16'd1, 16'd1);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("stall_readys", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      if (i >= 1) begin
        chk("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("stall_f", {16'd0, bus.rsp_f}, 32'd14);
        chk("stall_id", {31'd0, bus.rsp_id}, 32'd1);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("stall_release_readys", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    tick();
    chk("stall_after_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    wait_rsp("stall_next", 1'b0, 16'd2, 1'b0, 1'b0);

`ifdef ALU_ARBITER_DIVZ_EN
    issue(1'b0, 3'b011, 16'd5, 16'd0);
    wait_rsp("divz", 1'b0, 16'hFFFF, 1'b1, 1'b1);
    issue(1'b0, 3'b100, 16'h00FF, 16'h0000);
    wait_rsp("nota_err", 1'b0, 16'hFF00, 1'b0, 1'b1);
`else
    issue(1'b0, 3'b100, 16'h00FF, 16'h0000);
    wait_rsp("nota", 1'b0, 16'hFF00, 1'b0, 1'b1);
`endif

    // Logic ops.
    issue(1'b0, 3'b101, 16'hF0F0, 16'h0FF0);
    wait_rsp("xor", 1'b0, 16'hFF00, 1'b0, 1'b0);
    issue(1'b1, 3'b110, 16'hF0F0, 16'h0FF0);
    wait_rsp("or", 1'b1, 16'hFFF0, 1'b0, 1'b0);
    issue(1'b0, 3'b111, 16'hF0F0, 16'h0FF0);
    wait_rsp("and", 1'b0, 16'h00F0, 1'b0, 1'b0);

    // Reset while the op is in EXEC: it must vanish.
    issue(1'b1, 3'b000, 16'd9, 16'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_exec_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      tick();
    end

    // Reset while in RESP after requester 0 won: tie afterwards still goes to 0.
    bus.rsp_ready = 1'b0;
    issue(1'b0, 3'b000, 16'd2, 16'd2);
    tick();
    chk("rst_resp_pre_valid", {31'd0, bus.rsp_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_resp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    bus.rsp_ready = 1'b1;
    set_req(1'b0, 3'b110, 16'd1, 16'd2);
    set_req(1'b1, 3'b000, 16'd5, 16'd5);
    #1;
    chk("rst_tie_req0", {31'd0, bus.req0_ready}, 32'd1);
    chk("rst_tie_req1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_rsp("rst_tie_rsp", 1'b0, 16'd3, 1'b0, 1'b0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
